decode_alu_core: RTL and testbench
==================================

# decode_alu_core

Combined decode-and-execute core of the 5-stage RV32IM pipeline: a combinational instruction decoder (ID stage), a hazard bubble gate that zeroes pipeline controls on a load-use stall, and the EX-stage ALU with a multi-cycle multiply/divide unit. Decoder inputs come from the IF/ID register. ALU operands and opcode come from the ID/EX register. `mul_done`/`div_done` drive the pipeline stall logic.

## Interface
- No parameters.
- `clk` in 1: single clock, rising edge.
- `rst` in 1: synchronous, active-high.
- `opcode` in 7, `funct3` in 3, `funct7` in 7: instruction fields from IF/ID.
- `NOP` in 1: bubble request from hazard detection.
- `ImmType` out 3: ungated; 000 I, 001 S, 010 B, 011 U, 100 J.
- `B_Zero` out 1: ungated; branch polarity (taken = Branch & (Zero ^ B_Zero)).
- `isPC_select` out 2: ungated; ALU A-source: 00 rs1, 01 PC, 10 zero.
- `RegWriteHZ`, `MemWriteHZ`, `MemReadHZ`, `ALUSrcHZ`, `BranchHZ`, `JumpHZ`, `JumpRegHZ` out 1 each: gated controls.
- `ResultSrcHZ` out 2: gated; 00 ALU, 01 memory, 10 PC+4.
- `ImmTypeHZ` out 3, `ALUControlHZ` out 5: gated.
- `rdA`, `rdB` in 32: ALU operands.
- `ALUControl` in 5: EX-stage op.
- `ALUresult` out 32.
- `Carry`, `Zero` out 1.
- `mul_done`, `div_done` out 1.

## Operation
- **ALU op codes:**
  - 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 SLL, 6 SRL, 7 SRA, 8 SLT, 9 SLTU.
  - 16 MUL, 17 MULH, 18 MULHSU, 19 MULHU, 20 DIV, 21 DIVU, 22 REM, 23 REMU.
  - Other codes give result 0.
- **Decode:**
  - R 0110011:
    - funct7=0000001 → M op 16+funct3.
    - Otherwise funct3 → ADD/SUB (funct7[5]), SLL, SLT, SLTU, XOR, SRL/SRA (funct7[5]), OR, AND.
    - RegWrite=1.
  - I-ALU 0010011: same funct3 map, no SUB; SRAI when funct7[5]. ALUSrc=1, ImmType I, RegWrite=1.
  - Load 0000011: ADD, ALUSrc=1, MemRead=1, ResultSrc=01, RegWrite=1. funct3 ignored.
  - Store 0100011: ADD, ALUSrc=1, MemWrite=1, ImmType S.
  - Branch 1100011: Branch=1, ImmType B.
    - BEQ: SUB, B_Zero=0. BNE: SUB, B_Zero=1.
    - BLT: SLT, B_Zero=1. BGE: SLT, B_Zero=0.
    - BLTU: SLTU, B_Zero=1. BGEU: SLTU, B_Zero=0.
  - JAL 1101111: Jump=1, ImmType J, ResultSrc=10, RegWrite=1.
  - JALR 1100111: JumpReg=1, ADD, ALUSrc=1, ImmType I, ResultSrc=10, RegWrite=1.
  - LUI 0110111: isPC_select=10, ADD, ALUSrc=1, ImmType U, RegWrite=1.
  - AUIPC 0010111: isPC_select=01, ADD, ALUSrc=1, ImmType U, RegWrite=1.
  - Unknown opcode: all controls 0.
- **Gate:** NOP=1 forces every *HZ output to 0; ungated outputs are unaffected.
- **Single-cycle ALU ops:** combinational.
  - Shifts use rdB[4:0].
  - SLT/SLTU result is 1 or 0.
  - Carry: ADD → bit 32 of the unsigned sum. SUB → 1 iff rdA ≥ rdB unsigned. Other ops → 0.
  - Zero = (ALUresult == 0).
- **Multi-cycle unit (ALUControl[4]=1):** FSM IDLE → BUSY → DONE.
  - IDLE with M op present: latch operands and op at the edge.
  - MUL: compute product at that edge and go to DONE.
  - DIV/DIVU/REM/REMU: go to BUSY, restoring divider, one quotient bit per edge, 32 edges, then DONE.
  - DONE: assert the matching done flag and drive the result on ALUresult; next edge → IDLE.
  - ALUControl[4] dropping while BUSY aborts to IDLE with no done.
  - Signed ops use magnitudes, then fix the sign.
  - Divide by zero: quotient all-ones (−1), remainder = dividend.
  - DIV of 0x80000000 by −1: quotient 0x80000000, remainder 0.
  - During BUSY, ALUresult = 0 and both done flags are 0.

## Timing
- Decoder, gate and single-cycle ALU are purely combinational (zero latency).
- Cycle 0 is the first cycle an M op is seen in IDLE.
- MUL family: mul_done=1 in cycle 1 only.
- DIV family: div_done=1 in cycle 33 only.
- Done is high exactly one cycle. The pipeline advances at that edge.
- A back-to-back identical M op restarts from IDLE (cycle 0 = the cycle after done).
- Reset: while rst=1, all outputs are 0 (including Zero, Carry, ALUresult and the done flags). At the edge with rst=1 the FSM goes to IDLE, including an abort mid-division.

## Test plan
- R ADD, rdA=0xFFFFFFFF, rdB=1 → ALUresult=0, Carry=1, Zero=1. Decode gives RegWriteHZ=1, ALUControlHZ=0.
- opcode 1100011 funct3 001 (BNE) → BranchHZ=1, ALUControlHZ=1, B_Zero=1, ImmType=010. Same instruction with NOP=1 → all *HZ outputs 0, ImmType still 010.
- SRA with rdA=0x80000000, rdB=4 → 0xF8000000. SLTU with 1 vs 0xFFFFFFFF → 1.
- MUL with 7 and −3 → mul_done in cycle 1, ALUresult=0xFFFFFFEB. MULHU with 0xFFFFFFFF and 0xFFFFFFFF → 0xFFFFFFFE.
- DIV −7/2 → div_done in cycle 33 only, result 0xFFFFFFFD. REM −7/2 → 0xFFFFFFFF. DIVU x/0 → 0xFFFFFFFF. REM 5/0 → 5.
- rst=1 asserted at cycle 10 of a division → next cycle IDLE, div_done never asserted. After release, a new DIV completes normally.

Source files
------------

// File: rtl/decode_alu_core_if.sv
// decode_alu_core_if: decoder fields, pipeline controls and ALU operands/results shared by the decode/execute core
interface decode_alu_core_if;
    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic        NOP;
    logic [2:0]  ImmType;
    logic        B_Zero;
    logic [1:0]  isPC_select;
    logic        RegWriteHZ;
    logic        MemWriteHZ;
    logic        MemReadHZ;
    logic        ALUSrcHZ;
    logic        BranchHZ;
    logic        JumpHZ;
    logic        JumpRegHZ;
    logic [1:0]  ResultSrcHZ;
    logic [2:0]  ImmTypeHZ;
    logic [4:0]  ALUControlHZ;
    logic [31:0] rdA;
    logic [31:0] rdB;
    logic [4:0]  ALUControl;
    logic [31:0] ALUresult;
    logic        Carry;
    logic        Zero;
    logic        mul_done;
    logic        div_done;

    modport master (
        output opcode, funct3, funct7, NOP, rdA, rdB, ALUControl,
        input  ImmType, B_Zero, isPC_select, RegWriteHZ, MemWriteHZ, MemReadHZ, ALUSrcHZ,
               BranchHZ, JumpHZ, JumpRegHZ, ResultSrcHZ, ImmTypeHZ, ALUControlHZ,
               ALUresult, Carry, Zero, mul_done, div_done
    );

    modport slave (
        input  opcode, funct3, funct7, NOP, rdA, rdB, ALUControl,
        output ImmType, B_Zero, isPC_select, RegWriteHZ, MemWriteHZ, MemReadHZ, ALUSrcHZ,
               BranchHZ, JumpHZ, JumpRegHZ, ResultSrcHZ, ImmTypeHZ, ALUControlHZ,
               ALUresult, Carry, Zero, mul_done, div_done
    );
endinterface

// File: rtl/decode_alu_core.sv
// decode_alu_core: RV32IM instruction decoder with load-use bubble gate and EX-stage ALU with multi-cycle mul/div
module decode_alu_core (
    input logic         clk,
    input logic         rst,
    decode_alu_core_if.slave bus
);
    localparam logic [4:0] A_ADD = 5'd0, A_SUB = 5'd1, A_AND = 5'd2, A_OR = 5'd3, A_XOR = 5'd4;
    localparam logic [4:0] A_SLL = 5'd5, A_SRL = 5'd6, A_SRA = 5'd7, A_SLT = 5'd8, A_SLTU = 5'd9;

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    logic       rw, mw, mr, as, br, jp, jr, bz, kill;
    logic [1:0] rs_sel, pcs;
    logic [2:0] it;
    logic [4:0] ac, fop;

    // Decode the instruction fields into raw pipeline controls.
    always_comb begin
        rw = 1'b0; mw = 1'b0; mr = 1'b0; as = 1'b0; br = 1'b0; jp = 1'b0; jr = 1'b0; bz = 1'b0;
        rs_sel = 2'b00; pcs = 2'b00; it = 3'b000; ac = A_ADD; fop = A_ADD;
        case (bus.funct3)
            3'd1: fop = A_SLL;
            3'd2: fop = A_SLT;
            3'd3: fop = A_SLTU;
            3'd4: fop = A_XOR;
            3'd5: fop = A_SRL;
            3'd6: fop = A_OR;
            3'd7: fop = A_AND;
            default: fop = A_ADD;
        endcase
        case (bus.opcode)
            7'b0110011: begin
                rw = 1'b1;
                ac = (bus.funct7 == 7'b0000001) ? {2'b10, bus.funct3} :
                     (bus.funct7[5] && bus.funct3 == 3'd0) ? A_SUB :
                     (bus.funct7[5] && bus.funct3 == 3'd5) ? A_SRA : fop;
            end
            7'b0010011: begin
                rw = 1'b1; as = 1'b1;
                ac = (bus.funct7[5] && bus.funct3 == 3'd5) ? A_SRA : fop;
            end
            7'b0000011: begin rw = 1'b1; as = 1'b1; mr = 1'b1; rs_sel = 2'b01; end
            7'b0100011: begin as = 1'b1; mw = 1'b1; it = 3'b001; end
            7'b1100011: begin
                br = 1'b1; it = 3'b010;
                case (bus.funct3)
                    3'b100: begin ac = A_SLT;  bz = 1'b1; end
                    3'b101: begin ac = A_SLT;  bz = 1'b0; end
                    3'b110: begin ac = A_SLTU; bz = 1'b1; end
                    3'b111: begin ac = A_SLTU; bz = 1'b0; end
                    default: begin ac = A_SUB; bz = bus.funct3[0]; end
                endcase
            end
            7'b1101111: begin rw = 1'b1; jp = 1'b1; it = 3'b100; rs_sel = 2'b10; end
            7'b1100111: begin rw = 1'b1; jr = 1'b1; as = 1'b1; rs_sel = 2'b10; end
            7'b0110111: begin rw = 1'b1; as = 1'b1; it = 3'b011; pcs = 2'b10; end
            7'b0010111: begin rw = 1'b1; as = 1'b1; it = 3'b011; pcs = 2'b01; end
            default: ;
        endcase
    end

    // A bubble (or reset) clears every pipeline control; the informational outputs only clear on reset.
    assign kill = rst | bus.NOP;
    assign {bus.ImmType, bus.B_Zero, bus.isPC_select} = rst ? 6'd0 : {it, bz, pcs};
    assign {bus.RegWriteHZ, bus.MemWriteHZ, bus.MemReadHZ, bus.ALUSrcHZ, bus.BranchHZ, bus.JumpHZ,
            bus.JumpRegHZ, bus.ResultSrcHZ, bus.ImmTypeHZ, bus.ALUControlHZ} =
           kill ? 17'd0 : {rw, mw, mr, as, br, jp, jr, rs_sel, it, ac};

    logic [31:0] a, b, alu_res;
    logic        alu_c;
    assign a = bus.rdA;
    assign b = bus.rdB;

    // Single-cycle ALU; Carry means "no borrow" for SUB.
    always_comb begin
        alu_res = '0;
        alu_c = 1'b0;
        case (bus.ALUControl)
            A_ADD:  {alu_c, alu_res} = {1'b0, a} + {1'b0, b};
            A_SUB:  begin alu_res = a - b; alu_c = a >= b; end
            A_AND:  alu_res = a & b;
            A_OR:   alu_res = a | b;
            A_XOR:  alu_res = a ^ b;
            A_SLL:  alu_res = a << b[4:0];
            A_SRL:  alu_res = a >> b[4:0];
            A_SRA:  alu_res = $signed(a) >>> b[4:0];
            A_SLT:  alu_res = {31'd0, $signed(a) < $signed(b)};
            A_SLTU: alu_res = {31'd0, a < b};
            default: ;
        endcase
    end

    state_t      state, state_n;
    logic [2:0]  op_q;
    logic [31:0] a_q, b_q, q_q, r_q, am_in, bm, rsub, qv, rv, m_res, res;
    logic [63:0] ma, mb, prod;
    logic [32:0] rs;
    logic [4:0]  cnt;
    logic        m_start, ge;

    assign m_start = bus.ALUControl[4:3] == 2'b10;
    assign ma = {{32{bus.ALUControl[1:0] != 2'b11 && a[31]}}, a};
    assign mb = {{32{bus.ALUControl[1:0] == 2'b01 && b[31]}}, b};
    assign prod = ma * mb;
    assign am_in = (!bus.ALUControl[0] && a[31]) ? -a : a;
    assign bm = (!op_q[0] && b_q[31]) ? -b_q : b_q;
    assign rs = {r_q, q_q[31]};
    assign ge = rs >= {1'b0, bm};
    assign rsub = rs[31:0] - bm;
    assign qv = (b_q == '0) ? '1 : (!op_q[0] && (a_q[31] ^ b_q[31])) ? -q_q : q_q;
    assign rv = (b_q == '0) ? a_q : (!op_q[0] && a_q[31]) ? -r_q : r_q;
    assign m_res = !op_q[2] ? q_q : op_q[1] ? rv : qv;

    // State register for the mul/div sequencer.
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else state <= state_n;
    end

    // Next state: MUL finishes in one edge, divides take 32 edges, dropping the M op aborts a divide.
    always_comb begin
        state_n = IDLE;
        case (state)
            IDLE: state_n = m_start ? (bus.ALUControl[2] ? BUSY : DONE) : IDLE;
            BUSY: state_n = !bus.ALUControl[4] ? IDLE : (cnt == 5'd31) ? DONE : BUSY;
            default: state_n = IDLE;
        endcase
    end

    // Operand latch, one-edge multiply and restoring divider on magnitudes.
    always_ff @(posedge clk) begin
        if (state == IDLE && m_start) begin
            op_q <= bus.ALUControl[2:0];
            a_q <= a;
            b_q <= b;
            q_q <= bus.ALUControl[2] ? am_in : (bus.ALUControl[1:0] == 2'b00 ? prod[31:0] : prod[63:32]);
            r_q <= '0;
            cnt <= '0;
        end else if (state == BUSY) begin
            cnt <= cnt + 5'd1;
            r_q <= ge ? rsub : rs[31:0];
            q_q <= {q_q[30:0], ge};
        end
    end

    assign res = (rst || state == BUSY) ? '0 : (state == DONE) ? m_res : bus.ALUControl[4] ? '0 : alu_res;
    assign bus.ALUresult = res;
    assign bus.Carry = !rst && state == IDLE && alu_c;
    assign bus.Zero = !rst && res == '0;
    assign bus.mul_done = !rst && state == DONE && !op_q[2];
    assign bus.div_done = !rst && state == DONE && op_q[2];
endmodule

// File: tb/tb_decode_alu_core.sv
// tb_decode_alu_core: directed vectors checked against a behavioural model every cycle plus literal expectations
module tb_decode_alu_core;
    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;
    logic run = 1'b0;

    decode_alu_core_if bus ();
    decode_alu_core dut (.clk(clk), .rst(rst), .bus(bus));

    always #5 clk = ~clk;

    localparam logic [39:0] F3MAP = {5'd2, 5'd3, 5'd6, 5'd4, 5'd9, 5'd8, 5'd5, 5'd0};

    task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // {ImmType, B_Zero, isPC, RegWrite, MemWrite, MemRead, ALUSrc, Branch, Jump, JumpReg, ResultSrc, ALUControl}
    function automatic logic [19:0] dec_model(input logic [6:0] opc, input logic [2:0] f3, input logic [6:0] f7);
        logic [4:0] m;
        logic [39:0] map;
        map = F3MAP;
        m = map[f3*5 +: 5];
        case (opc)
            7'b0110011: return (f7 == 7'd1) ? {3'd0, 1'b0, 2'd0, 7'b1000000, 2'd0, 5'd16 + {2'd0, f3}}
                                            : {3'd0, 1'b0, 2'd0, 7'b1000000, 2'd0, m + {4'd0, f7[5] && (f3 == 0 || f3 == 5)}};
            7'b0010011: return {3'd0, 1'b0, 2'd0, 7'b1001000, 2'd0, m + {4'd0, f7[5] && f3 == 5}};
            7'b0000011: return {3'd0, 1'b0, 2'd0, 7'b1011000, 2'd1, 5'd0};
            7'b0100011: return {3'd1, 1'b0, 2'd0, 7'b0101000, 2'd0, 5'd0};
            7'b1100011: return {3'd2, f3[0] ^ f3[2], 2'd0, 7'b0000100, 2'd0, f3[2] ? (f3[1] ? 5'd9 : 5'd8) : 5'd1};
            7'b1101111: return {3'd4, 1'b0, 2'd0, 7'b1000010, 2'd2, 5'd0};
            7'b1100111: return {3'd0, 1'b0, 2'd0, 7'b1001001, 2'd2, 5'd0};
            7'b0110111: return {3'd3, 1'b0, 2'd2, 7'b1001000, 2'd0, 5'd0};
            7'b0010111: return {3'd3, 1'b0, 2'd1, 7'b1001000, 2'd0, 5'd0};
            default:    return 20'd0;
        endcase
    endfunction

    // {Carry, result} of a single-cycle op
    function automatic logic [32:0] alu_model(input logic [4:0] op, input logic [31:0] x, input logic [31:0] y);
        int sx, sy;
        sx = x; sy = y;
        case (op)
            5'd0: return {1'b0, x} + {1'b0, y};
            5'd1: return {x >= y, x - y};
            5'd2: return {1'b0, x & y};
            5'd3: return {1'b0, x | y};
            5'd4: return {1'b0, x ^ y};
            5'd5: return {1'b0, x << y[4:0]};
            5'd6: return {1'b0, x >> y[4:0]};
            5'd7: return {1'b0, sx >>> y[4:0]};
            5'd8: return {32'd0, sx < sy};
            5'd9: return {32'd0, x < y};
            default: return 33'd0;
        endcase
    endfunction

    function automatic logic [31:0] m_model(input logic [4:0] op, input logic [31:0] x, input logic [31:0] y);
        int sx, sy;
        longint p, ux, uy;
        logic ovf;
        sx = x; sy = y;
        ux = {32'd0, x}; uy = {32'd0, y};
        ovf = (x == 32'h8000_0000) && (y == 32'hFFFF_FFFF);
        case (op)
            5'd16: p = longint'(sx) * longint'(sy);
            5'd17: p = (longint'(sx) * longint'(sy)) >>> 32;
            5'd18: p = (longint'(sx) * uy) >>> 32;
            5'd19: p = (ux * uy) >> 32;
            5'd20: p = (y == 0) ? -1 : ovf ? longint'(x) : longint'(sx / sy);
            5'd21: p = (y == 0) ? -1 : ux / uy;
            5'd22: p = (y == 0) ? longint'(x) : ovf ? 0 : longint'(sx % sy);
            5'd23: p = (y == 0) ? longint'(x) : ux % uy;
            default: p = 0;
        endcase
        return p[31:0];
    endfunction

    logic        m_act = 1'b0;
    int          m_cnt = 0;
    logic [4:0]  m_op;
    logic [31:0] m_a, m_b;
    int          m_lat;
    assign m_lat = (m_op >= 5'd20) ? 33 : 1;

    // Model of the M-op timeline: cycles elapsed since the op was accepted.
    always @(posedge clk) begin
        if (rst) m_act <= 1'b0;
        else if (!m_act) begin
            if (bus.ALUControl >= 5'd16 && bus.ALUControl <= 5'd23) begin
                m_act <= 1'b1; m_cnt <= 1; m_op <= bus.ALUControl; m_a <= bus.rdA; m_b <= bus.rdB;
            end
        end else if (m_cnt == m_lat) m_act <= 1'b0;
        else if (!bus.ALUControl[4]) m_act <= 1'b0;
        else m_cnt <= m_cnt + 1;
    end

    // Compare every output against the model on each falling edge.
    always @(negedge clk) begin
        logic [19:0] d;
        logic [32:0] s;
        logic [31:0] er;
        logic        ec, emd, edd;
        if (run) begin
            d = dec_model(bus.opcode, bus.funct3, bus.funct7);
            er = 0; ec = 0; emd = 0; edd = 0;
            if (!rst) begin
                if (m_act && m_cnt == m_lat) begin
                    er = m_model(m_op, m_a, m_b);
                    emd = m_op < 5'd20;
                    edd = m_op >= 5'd20;
                end else if (!m_act && !bus.ALUControl[4]) begin
                    s = alu_model(bus.ALUControl, bus.rdA, bus.rdB);
                    {ec, er} = s;
                end
            end
            cmp("ungated decode", {26'd0, bus.ImmType, bus.B_Zero, bus.isPC_select}, rst ? 32'd0 : {26'd0, d[19:14]});
            cmp("gated decode", {15'd0, bus.RegWriteHZ, bus.MemWriteHZ, bus.MemReadHZ, bus.ALUSrcHZ, bus.BranchHZ,
                bus.JumpHZ, bus.JumpRegHZ, bus.ResultSrcHZ, bus.ImmTypeHZ, bus.ALUControlHZ},
                (rst || bus.NOP) ? 32'd0 : {15'd0, d[13:5], d[19:17], d[4:0]});
            cmp("ALUresult", bus.ALUresult, er);
            cmp("Carry", {31'd0, bus.Carry}, {31'd0, ec});
            cmp("Zero", {31'd0, bus.Zero}, {31'd0, !rst && er == 0});
            cmp("mul_done", {31'd0, bus.mul_done}, {31'd0, emd});
            cmp("div_done", {31'd0, bus.div_done}, {31'd0, edd});
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic inst(input logic [6:0] opc, input logic [2:0] f3, input logic [6:0] f7, input logic nop);
        bus.opcode = opc; bus.funct3 = f3; bus.funct7 = f7; bus.NOP = nop;
    endtask

    task automatic run_m(input logic [4:0] op, input logic [31:0] x, input logic [31:0] y,
                         input logic [31:0] exp, input int lat, input string nm);
        int seen;
        seen = -1;
        tick();
        bus.ALUControl = op; bus.rdA = x; bus.rdB = y;
        @(negedge clk);
        for (int i = 1; i <= 40 && seen < 0; i++) begin
            tick();
            @(negedge clk);
            if (bus.mul_done || bus.div_done) begin
                seen = i;
                cmp({nm, " result"}, bus.ALUresult, exp);
            end
        end
        cmp({nm, " done cycle"}, seen, lat);
        tick();
        bus.ALUControl = 5'd0;
        @(negedge clk);
    endtask

    logic [16:0] insts [14] = '{
        {7'b0110011, 3'd0, 7'h20}, {7'b0110011, 3'd5, 7'h20}, {7'b0110011, 3'd3, 7'h01},
        {7'b0110011, 3'd7, 7'h00}, {7'b0010011, 3'd5, 7'h20}, {7'b0010011, 3'd2, 7'h00},
        {7'b0000011, 3'd2, 7'h00}, {7'b0100011, 3'd2, 7'h00}, {7'b1100011, 3'd4, 7'h00},
        {7'b1100011, 3'd7, 7'h00}, {7'b1101111, 3'd0, 7'h00}, {7'b1100111, 3'd0, 7'h00},
        {7'b0110111, 3'd0, 7'h00}, {7'b0010111, 3'd0, 7'h00}};

    logic [100:0] alu_vec [8] = '{
        {5'd7, 32'h8000_0000, 32'd4, 32'hF800_0000}, {5'd9, 32'd1, 32'hFFFF_FFFF, 32'd1},
        {5'd8, 32'hFFFF_FFFF, 32'd1, 32'd1},         {5'd1, 32'd5, 32'd7, 32'hFFFF_FFFE},
        {5'd5, 32'd1, 32'd33, 32'd2},                {5'd6, 32'h8000_0000, 32'd31, 32'd1},
        {5'd4, 32'hF0F0_F0F0, 32'hFFFF_0000, 32'h0F0F_F0F0}, {5'd10, 32'd5, 32'd3, 32'd0}};

    initial begin
        int n;
        logic [100:0] v;
        rst = 1'b1;
        inst(7'b0110011, 3'd0, 7'd0, 1'b0);
        bus.ALUControl = 5'd0; bus.rdA = 32'hFFFF_FFFF; bus.rdB = 32'd1;
        run = 1'b1;
        repeat (2) @(negedge clk);
        cmp("reset Carry", {31'd0, bus.Carry}, 32'd0);
        cmp("reset Zero", {31'd0, bus.Zero}, 32'd0);
        cmp("reset RegWriteHZ", {31'd0, bus.RegWriteHZ}, 32'd0);
        tick();
        rst = 1'b0;
        @(negedge clk);
        cmp("ADD result", bus.ALUresult, 32'd0);
        cmp("ADD Carry", {31'd0, bus.Carry}, 32'd1);
        cmp("ADD Zero", {31'd0, bus.Zero}, 32'd1);
        cmp("ADD RegWriteHZ", {31'd0, bus.RegWriteHZ}, 32'd1);
        cmp("ADD ALUControlHZ", {27'd0, bus.ALUControlHZ}, 32'd0);
        tick();
        inst(7'b1100011, 3'd1, 7'd0, 1'b0);
        @(negedge clk);
        cmp("BNE BranchHZ", {31'd0, bus.BranchHZ}, 32'd1);
        cmp("BNE ALUControlHZ", {27'd0, bus.ALUControlHZ}, 32'd1);
        cmp("BNE B_Zero", {31'd0, bus.B_Zero}, 32'd1);
        cmp("BNE ImmType", {29'd0, bus.ImmType}, 32'd2);
        tick();
        bus.NOP = 1'b1;
        @(negedge clk);
        cmp("NOP BranchHZ", {31'd0, bus.BranchHZ}, 32'd0);
        cmp("NOP ALUControlHZ", {27'd0, bus.ALUControlHZ}, 32'd0);
        cmp("NOP ImmType", {29'd0, bus.ImmType}, 32'd2);
        cmp("NOP B_Zero", {31'd0, bus.B_Zero}, 32'd1);
        for (int i = 0; i < 14; i++) begin
            tick();
            inst(insts[i][16:10], insts[i][9:7], insts[i][6:0], i[0]);
            @(negedge clk);
        end
        cmp("AUIPC isPC_select", {30'd0, bus.isPC_select}, 32'd1);
        tick();
        inst(7'b1111111, 3'd0, 7'd0, 1'b0);
        for (int i = 0; i < 8; i++) begin
            v = alu_vec[i];
            tick();
            bus.ALUControl = v[100:96]; bus.rdA = v[95:64]; bus.rdB = v[63:32];
            @(negedge clk);
            cmp($sformatf("ALU op %0d", v[100:96]), bus.ALUresult, v[31:0]);
        end
        run_m(5'd16, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB, 1, "MUL");
        run_m(5'd19, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 1, "MULHU");
        run_m(5'd17, 32'hFFFF_FFFE, 32'd3, 32'hFFFF_FFFF, 1, "MULH");
        run_m(5'd18, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1, "MULHSU");
        run_m(5'd20, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 33, "DIV");
        run_m(5'd22, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 33, "REM");
        run_m(5'd21, 32'h0000_1234, 32'd0, 32'hFFFF_FFFF, 33, "DIVU by 0");
        run_m(5'd22, 32'd5, 32'd0, 32'd5, 33, "REM by 0");
        run_m(5'd20, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 33, "DIV overflow");
        run_m(5'd23, 32'd10, 32'd3, 32'd1, 33, "REMU");
        tick();
        bus.ALUControl = 5'd16; bus.rdA = 32'd3; bus.rdB = 32'd5;
        @(negedge clk);
        n = 0;
        for (int i = 1; i <= 4; i++) begin
            tick();
            @(negedge clk);
            n += int'(bus.mul_done);
        end
        cmp("back-to-back MUL dones", n, 2);
        tick();
        bus.ALUControl = 5'd0;
        repeat (2) @(negedge clk);
        tick();
        bus.ALUControl = 5'd20; bus.rdA = 32'd100; bus.rdB = 32'd7;
        @(negedge clk);
        n = 0;
        for (int i = 1; i <= 9; i++) begin
            tick();
            @(negedge clk);
            n += int'(bus.div_done);
        end
        tick();
        rst = 1'b1;
        @(negedge clk);
        cmp("rst ALUresult", bus.ALUresult, 32'd0);
        tick();
        rst = 1'b0;
        bus.ALUControl = 5'd0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            n += int'(bus.div_done);
        end
        cmp("aborted div_done count", n, 0);
        run_m(5'd20, 32'd100, 32'd7, 32'd14, 33, "DIV after reset");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete, errors so far %0d", errors);
        $fatal(1);
    end
endmodule
